// File: rtl/wb_uart_tx_target_pkg.sv
// wb_uart_tx_target_pkg
// Shared definitions for the Wishbone UART transmit target: register offsets
// (word index taken from wb_adr_i[3:2]), STATUS/CTRL bit positions, and the
// 2-bit serialiser state encoding.
package wb_uart_tx_target_pkg;

  // Register word offsets (byte addresses 0x0, 0x4, 0x8, 0xC)
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_TX_INT_EN = 0;

  // Serialiser states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // An access is rejected when it is outside the 16-byte window or is not a
  // full-word access.
  function automatic logic is_bad_access(input logic [23:0] adr,
                                         input logic [3:0]  sel);
    return (adr[23:4] != 20'd0) || (sel != 4'b1111);
  endfunction

endpackage

// File: rtl/wb_uart_tx_target_fifo.sv
// sync_fifo_byte
// Synchronous byte FIFO with 2**DEPTH_LOG2 entries. Pointers carry one extra
// wrap bit so full/empty are distinguished and count = wr_ptr - rd_ptr.
// A push while full is accepted when a pop happens on the same edge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (flushes FIFO)
//   push, din[7:0]    write request and data
//   pop               read request; dout shows the head entry combinationally
//   full, empty       status flags
//   count             number of stored bytes, 0..2**DEPTH_LOG2
module sync_fifo_byte
  import wb_uart_tx_target_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  output logic [7:0]            dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          mem_d [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one being popped this edge.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/wb_uart_tx_target.sv
// wb_uart_tx_target
// Wishbone classic slave that buffers CPU-written bytes in a TX FIFO and
// serialises them as 8N1 on uart_tx_o, with a level "transmit done" interrupt.
// Ports:
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   wb_adr_i[23:0]         byte address; [3:2] register select, [23:4] must be 0
//   wb_dat_i/wb_dat_o      write / read data (read data is 0 outside ack)
//   wb_sel_i, wb_we_i      byte selects (must be 4'b1111), write enable
//   wb_cyc_i, wb_stb_i     cycle / strobe
//   wb_ack_o, wb_err_o     registered single-cycle responses
//   uart_tx_o              serial output, idle high
//   uart_int_o             tx_int_en & fifo empty & serialiser idle, registered
// Registers: 0x0 TXDATA (W), 0x4 STATUS (R, W1C overflow), 0x8 CTRL, 0xC DIVISOR.
module wb_uart_tx_target
  import wb_uart_tx_target_pkg::*;
#(
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter logic [15:0] DIVISOR_RESET   = 16'd433
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        uart_tx_o,
  output logic        uart_int_o
);

  localparam int CW = FIFO_DEPTH_LOG2 + 1;

  // ---------------------------------------------------------------------------
  // Bus handshake: a request is cyc & stb while neither ack nor err is high.
  // Each request gets exactly one of ack/err on the next edge for one cycle;
  // because the response itself masks the request, the response always drops
  // for at least one cycle, giving a minimum of two clocks per access. Write
  // side effects land on the same edge that raises ack.
  // ---------------------------------------------------------------------------
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic        bus_req, bad_access, wr_en, rd_en;
  logic [1:0]  reg_sel;

  logic        ctrl_q, ctrl_d;
  logic [15:0] divisor_q, divisor_d;
  logic        ovf_q, ovf_d;
  logic        int_q, int_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        busy, bit_end;

  logic [31:0] status_word, rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb_adr_i[1:0], wb_dat_i[31:16]};

  assign bus_req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign bad_access = is_bad_access(wb_adr_i, wb_sel_i);
  assign reg_sel    = wb_adr_i[3:2];
  assign wr_en      = bus_req & ~bad_access &  wb_we_i;
  assign rd_en      = bus_req & ~bad_access & ~wb_we_i;

  assign fifo_push  = wr_en & (reg_sel == REG_TXDATA);
  assign busy       = (state_q != TX_IDLE);
  assign bit_end    = (cnt_q == 16'd0);

  sync_fifo_byte #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .push  (fifo_push),
    .din   (wb_dat_i[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    status_word                          = 32'd0;
    status_word[STAT_FULL]               = fifo_full;
    status_word[STAT_EMPTY]              = fifo_empty;
    status_word[STAT_BUSY]               = busy;
    status_word[STAT_OVF]                = ovf_q;
    status_word[STAT_COUNT_LSB +: CW]    = fifo_count;
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_STATUS:  rdata = status_word;
      REG_CTRL:    rdata = {31'd0, ctrl_q};
      REG_DIVISOR: rdata = {16'd0, divisor_q};
      default:     rdata = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus response and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_d     = bus_req & ~bad_access;
    err_d     = bus_req &  bad_access;
    dat_d     = rd_en ? rdata : 32'd0;
    ctrl_d    = ctrl_q;
    divisor_d = divisor_q;
    ovf_d     = ovf_q;
    if (wr_en) begin
      case (reg_sel)
        // A pop on the same edge frees a slot, so that push is not an overflow.
        REG_TXDATA:  if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        REG_STATUS:  if (wb_dat_i[STAT_OVF]) ovf_d = 1'b0;
        REG_CTRL:    ctrl_d = wb_dat_i[CTRL_TX_INT_EN];
        REG_DIVISOR: divisor_d = wb_dat_i[15:0];
        default:     ;
      endcase
    end
    int_d = ctrl_q & fifo_empty & ~busy;
  end

  // ---------------------------------------------------------------------------
  // Serialiser: every state/bit lasts DIVISOR+1 clocks. The down-counter is
  // reloaded only at bit boundaries, so a DIVISOR write takes effect at the
  // next boundary. The shift register is pre-shifted so bit 0 is always the
  // next data bit to send.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          cnt_d    = divisor_q;
          state_d  = TX_START;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          cnt_d   = divisor_q;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = divisor_q;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          // Back-to-back frames: go straight to START with no idle bit.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            cnt_d    = divisor_q;
            state_d  = TX_START;
            tx_d     = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= 32'd0;
      ctrl_q    <= 1'b0;
      divisor_q <= DIVISOR_RESET;
      ovf_q     <= 1'b0;
      int_q     <= 1'b0;
      state_q   <= TX_IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      ctrl_q    <= ctrl_d;
      divisor_q <= divisor_d;
      ovf_q     <= ovf_d;
      int_q     <= int_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_dat_o   = dat_q;
  assign uart_tx_o  = tx_q;
  assign uart_int_o = int_q;

endmodule
